// File: rtl/xt_hb_dma.sv
// xt_hb_dma: single-channel word-copy DMA master for the high-speed bus; `XT_HB_DMA_FILL_EN adds pattern-fill mode.
package XT_HBUS_Pkg;
  localparam int HB_ADDR_WIDTH = 32;
  localparam int HB_DATA = 32;
  localparam logic [1:0] HB_WIDTH_WORD = 2'b10;
  typedef struct packed {
    logic                     read;
    logic                     write;
    logic [HB_ADDR_WIDTH-1:0] raddr;
    logic [HB_ADDR_WIDTH-1:0] waddr;
    logic [HB_DATA-1:0]       wdata;
    logic [1:0]               write_width;
  } hb_master_in_t;
endpackage

module xt_hb_dma
  import XT_HBUS_Pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_sync,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic [HB_ADDR_WIDTH-1:0] cfg_src,
  input  logic [HB_ADDR_WIDTH-1:0] cfg_dst,
  input  logic [LEN_WIDTH-1:0]     cfg_len,
`ifdef XT_HB_DMA_FILL_EN
  input  logic                     cfg_fill,
  input  logic [31:0]              cfg_pattern,
`endif
  output hb_master_in_t            master_out,
  input  logic                     read_grant,
  input  logic                     write_grant,
  input  logic                     stall_req,
  input  logic [HB_DATA-1:0]       hb_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [LEN_WIDTH-1:0]     words_left
);
  localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  localparam logic [HB_ADDR_WIDTH-1:0] STEP = HB_ADDR_WIDTH'(4);
  localparam logic [HB_ADDR_WIDTH-1:0] ALIGN = ~HB_ADDR_WIDTH'(3);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic [HB_DATA-1:0] mem [2**AW];
  logic [CW-1:0] wp, rp, rp_n;
  logic [HB_ADDR_WIDTH-1:0] src, dst, src_a, dst_a;
  logic rd_ok, wr_ok, last_word;
`ifdef XT_HB_DMA_FILL_EN
  logic fill;
  logic [31:0] pattern;
  logic start_fill;
  logic [31:0] start_pat;
  assign start_fill = cfg_fill;
  assign start_pat = cfg_pattern;
`else
  localparam logic fill = 1'b0;
  localparam logic [31:0] pattern = '0;
  localparam logic start_fill = 1'b0;
  localparam logic [31:0] start_pat = '0;
`endif
  assign src_a = cfg_src & ALIGN;
  assign dst_a = cfg_dst & ALIGN;
  assign rd_ok = master_out.read & read_grant & ~stall_req;
  assign wr_ok = master_out.write & write_grant & ~stall_req;
  assign rp_n = rp + CW'(1);
  assign last_word = words_left == LEN_WIDTH'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (state == READ && rd_ok) mem[wp[AW-1:0]] <= hb_rdata;
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state <= IDLE;
      master_out <= '0;
      aborted <= 1'b0;
      words_left <= '0;
      src <= '0;
      dst <= '0;
      wp <= '0;
      rp <= '0;
`ifdef XT_HB_DMA_FILL_EN
      fill <= 1'b0;
      pattern <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cfg_start && !cfg_abort) begin
          src <= src_a;
          dst <= dst_a;
          words_left <= cfg_len;
          aborted <= 1'b0;
          wp <= '0;
          rp <= '0;
`ifdef XT_HB_DMA_FILL_EN
          fill <= cfg_fill;
          pattern <= cfg_pattern;
`endif
          if (cfg_len == '0) state <= DONE;
          else if (start_fill) begin
            state <= WRITE;
            master_out.write <= 1'b1;
            master_out.waddr <= dst_a;
            master_out.wdata <= start_pat;
            master_out.write_width <= HB_WIDTH_WORD;
          end else begin
            state <= READ;
            master_out.read <= 1'b1;
            master_out.raddr <= src_a;
          end
        end
        READ: if (cfg_abort) begin
          state <= DONE;
          aborted <= 1'b1;
          master_out <= '0;
          wp <= '0;
          rp <= '0;
        end else if (rd_ok) begin
          src <= src + STEP;
          words_left <= words_left - LEN_WIDTH'(1);
          wp <= wp + CW'(1);
          if (wp + CW'(1) == FULL || last_word) begin
            state <= WRITE;
            rp <= '0;
            master_out.read <= 1'b0;
            master_out.write <= 1'b1;
            master_out.waddr <= dst;
            // First word of a burst may be arriving this very cycle
            master_out.wdata <= wp == '0 ? hb_rdata : mem[0];
            master_out.write_width <= HB_WIDTH_WORD;
          end else master_out.raddr <= src + STEP;
        end
        WRITE: if (cfg_abort) begin
          state <= DONE;
          aborted <= 1'b1;
          master_out <= '0;
          wp <= '0;
          rp <= '0;
        end else if (wr_ok) begin
          dst <= dst + STEP;
          rp <= rp_n;
          if (fill) words_left <= words_left - LEN_WIDTH'(1);
          if (fill ? last_word : rp_n == wp) begin
            wp <= '0;
            rp <= '0;
            master_out.write <= 1'b0;
            master_out.write_width <= 2'b00;
            if (!fill && words_left != '0) begin
              state <= READ;
              master_out.read <= 1'b1;
              master_out.raddr <= src;
            end else state <= DONE;
          end else begin
            master_out.waddr <= dst + STEP;
            master_out.wdata <= fill ? pattern : mem[rp_n[AW-1:0]];
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xt_hb_dma.sv
// tb_xt_hb_dma: randomized bus-responder bench for xt_hb_dma with a transfer-level reference model.
module tb_xt_hb_dma;
  import XT_HBUS_Pkg::*;
  localparam int BD = 4;
  logic clk = 1'b0;
  logic rst_sync, cfg_start, cfg_abort;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
`ifdef XT_HB_DMA_FILL_EN
  logic cfg_fill;
  logic [31:0] cfg_pattern;
`endif
  hb_master_in_t master_out;
  logic read_grant, write_grant, stall_req;
  logic [31:0] hb_rdata;
  logic busy, done, aborted;
  logic [15:0] words_left;

  xt_hb_dma #(.BUF_DEPTH(BD), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_sync(rst_sync), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
`ifdef XT_HB_DMA_FILL_EN
    .cfg_fill(cfg_fill), .cfg_pattern(cfg_pattern),
`endif
    .master_out(master_out), .read_grant(read_grant), .write_grant(write_grant),
    .stall_req(stall_req), .hb_rdata(hb_rdata), .busy(busy), .done(done),
    .aborted(aborted), .words_left(words_left));

  always #5 clk = ~clk;

  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} ev_t;
  ev_t obs[$], expq[$];
  int checks = 0, passed = 0;
  logic [31:0] seed = 32'h1234_5678;
  int stall_pct, gl_pct, mode, abort_on_wr;
  int n_done, n_busy, hold_err, first_rd, first_wr, done_cyc, abort_cyc, n_rd, n_wr;
  hb_master_in_t mo_at_done;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction
  assign hb_rdata = mem_val(master_out.raddr);

  // Expected bus traffic: bursts of up to BD reads followed by the same words written out
  task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input int len, input logic f, input logic [31:0] p);
    logic [31:0] sa, da;
    sa = s & ~32'd3;
    da = d & ~32'd3;
    expq.delete();
    if (f) for (int i = 0; i < len; i++) expq.push_back({1'b1, da + 32'(4 * i), p});
    else for (int b = 0; b < len; b += BD) begin
      int n;
      n = (len - b < BD) ? len - b : BD;
      for (int i = 0; i < n; i++) expq.push_back({1'b0, sa + 32'(4 * (b + i)), mem_val(sa + 32'(4 * (b + i)))});
      for (int i = 0; i < n; i++) expq.push_back({1'b1, da + 32'(4 * (b + i)), mem_val(sa + 32'(4 * (b + i)))});
    end
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, input logic f, input logic [31:0] p);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = l;
`ifdef XT_HB_DMA_FILL_EN
    cfg_fill = f;
    cfg_pattern = p;
`else
    if (f || p != 0) $display("note: fill requested without fill build");
`endif
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  // Plays bus slave cycle by cycle, logging completed beats and protocol-hold violations
  task automatic run(input int budget);
    hb_master_in_t prev;
    logic pend, rc, wc;
    int wait_c, post;
    obs.delete();
    {n_done, n_busy, hold_err, n_rd, n_wr} = '0;
    first_rd = -1; first_wr = -1; done_cyc = -1; abort_cyc = -1;
    pend = 1'b0; wait_c = 0; post = -1; prev = '0; mo_at_done = '0;
    for (int c = 0; c < budget && post != 0; c++) begin
      cfg_abort = 1'b0;
      if (mode == 1) begin
        read_grant = 1'b1;
        stall_req = master_out.read && wait_c < 3;
        write_grant = !(master_out.write && n_wr == 0 && wait_c < 2);
      end else begin
        stall_req = $urandom_range(99) < stall_pct;
        read_grant = $urandom_range(99) >= gl_pct;
        write_grant = $urandom_range(99) >= gl_pct;
      end
      if (abort_on_wr >= 0 && master_out.write && n_wr == abort_on_wr) begin
        stall_req = 1'b1;
        cfg_abort = 1'b1;
        abort_on_wr = -1;
        abort_cyc = c;
      end
      @(negedge clk);
      if (master_out.read && master_out.write) hold_err++;
      if (master_out.write && master_out.write_width !== HB_WIDTH_WORD) hold_err++;
      if (pend && master_out !== prev) hold_err++;
      rc = master_out.read && read_grant && !stall_req;
      wc = master_out.write && write_grant && !stall_req;
      if (rc) begin obs.push_back({1'b0, master_out.raddr, hb_rdata}); if (first_rd < 0) first_rd = c; n_rd++; end
      if (wc) begin obs.push_back({1'b1, master_out.waddr, master_out.wdata}); if (first_wr < 0) first_wr = c; n_wr++; end
      pend = (master_out.read || master_out.write) && !rc && !wc && !cfg_abort;
      prev = master_out;
      wait_c = (rc || wc || !(master_out.read || master_out.write)) ? 0 : wait_c + 1;
      if (busy) n_busy++;
      if (done) n_done++;
      if (done && post < 0) begin post = 3; done_cyc = c; mo_at_done = master_out; end
      if (post > 0) post--;
      @(posedge clk); #1;
    end
    read_grant = 1'b1; write_grant = 1'b1; stall_req = 1'b0; cfg_abort = 1'b0;
    if (post != 0) begin
      checks++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    rst_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_sync = 1'b0;
    @(negedge clk);
    checks++; if (master_out !== '0) $display("FAIL reset_master_out got %h exp 0", master_out); else passed++;
    checks++; if ({busy, done, aborted} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {busy, done, aborted}); else passed++;
    checks++; if (words_left !== 16'd0) $display("FAIL reset_words_left got %0d exp 0", words_left); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_abort;
    int bad;
    bad = 0;
    cfg_len = 16'd3; cfg_src = 32'h40; cfg_dst = 32'h80;
    cfg_start = 1'b1; cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_abort = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done || master_out.read || master_out.write) bad++;
    end
    @(posedge clk); #1;
    checks++; if (bad !== 0) $display("FAIL idle_start_abort activity got %0d exp 0", bad); else passed++;
  endtask

  task automatic test_len1_latency;
    mode = 0; stall_pct = 0; gl_pct = 0; abort_on_wr = -1;
    build_exp(32'h500, 32'h600, 1, 1'b0, 0);
    start(32'h500, 32'h600, 16'd1, 1'b0, 0);
    run(50);
    checks++; if (first_rd !== 0) $display("FAIL len1_read_cycle got %0d exp 0", first_rd); else passed++;
    checks++; if (first_wr !== 1) $display("FAIL len1_write_cycle got %0d exp 1", first_wr); else passed++;
    checks++; if (done_cyc !== 2) $display("FAIL len1_done_cycle got %0d exp 2", done_cyc); else passed++;
    checks++; if (obs.size() !== 2 || obs[1] !== expq[1]) $display("FAIL len1_write_beat got %h exp %h", obs.size() > 1 ? obs[1] : '0, expq[1]); else passed++;
  endtask

  task automatic test_zero_len;
    mode = 0; stall_pct = 0; gl_pct = 0; abort_on_wr = -1;
    start(32'h700, 32'h800, 16'd0, 1'b0, 0);
    run(20);
    checks++; if (n_rd + n_wr !== 0) $display("FAIL zero_len_beats got %0d exp 0", n_rd + n_wr); else passed++;
    checks++; if (done_cyc !== 0) $display("FAIL zero_len_done_cycle got %0d exp 0", done_cyc); else passed++;
    checks++; if (n_busy !== 1) $display("FAIL zero_len_busy_cycles got %0d exp 1", n_busy); else passed++;
  endtask

  task automatic test_copy6(input int m);
    seed = $urandom;
    mode = m; stall_pct = 0; gl_pct = 0; abort_on_wr = -1;
    build_exp(32'h100, 32'h200, 6, 1'b0, 0);
    start(32'h100, 32'h200, 16'd6, 1'b0, 0);
    run(300);
    checks++; if (obs.size() !== expq.size()) $display("FAIL copy6_m%0d_beats got %0d exp %0d", m, obs.size(), expq.size()); else passed++;
    foreach (expq[i]) if (i < obs.size()) begin
      checks++; if (obs[i] !== expq[i]) $display("FAIL copy6_m%0d_beat%0d got %h exp %h", m, i, obs[i], expq[i]); else passed++;
    end
    checks++; if (hold_err !== 0) $display("FAIL copy6_m%0d_hold got %0d exp 0", m, hold_err); else passed++;
    checks++; if (n_done !== 1 || aborted !== 1'b0) $display("FAIL copy6_m%0d_done_aborted got %0d/%b exp 1/0", m, n_done, aborted); else passed++;
    checks++; if (words_left !== 16'd0) $display("FAIL copy6_m%0d_words_left got %0d exp 0", m, words_left); else passed++;
  endtask

  task automatic test_abort;
    mode = 0; stall_pct = 0; gl_pct = 0; abort_on_wr = 1;
    start(32'h1000, 32'h2000, 16'd8, 1'b0, 0);
    run(200);
    checks++; if (n_wr !== 1) $display("FAIL abort_writes got %0d exp 1", n_wr); else passed++;
    checks++; if (abort_cyc < 0 || done_cyc !== abort_cyc + 1) $display("FAIL abort_done_cycle got %0d exp %0d", done_cyc, abort_cyc + 1); else passed++;
    checks++; if (mo_at_done.write !== 1'b0) $display("FAIL abort_write_dropped got %b exp 0", mo_at_done.write); else passed++;
    checks++; if (aborted !== 1'b1 || n_done !== 1) $display("FAIL abort_flags got %b/%0d exp 1/1", aborted, n_done); else passed++;
  endtask

  task automatic test_reset_mid_read;
    seed = $urandom;
    start(32'h300, 32'h340, 16'd4, 1'b0, 0);
    stall_req = 1'b1; read_grant = 1'b1;
    @(posedge clk); #1;
    checks++; if (master_out.read !== 1'b1) $display("FAIL midread_pending got %b exp 1", master_out.read); else passed++;
    rst_sync = 1'b1;
    @(posedge clk); #1;
    rst_sync = 1'b0; stall_req = 1'b0;
    @(negedge clk);
    checks++; if (master_out !== '0 || busy !== 1'b0) $display("FAIL midread_reset got %h/%b exp 0/0", master_out, busy); else passed++;
    checks++; if ({done, aborted, words_left} !== '0) $display("FAIL midread_reset_status got %b/%b/%0d exp 0/0/0", done, aborted, words_left); else passed++;
    @(posedge clk); #1;
    mode = 0; stall_pct = 20; gl_pct = 20; abort_on_wr = -1;
    build_exp(32'h900, 32'hA00, 2, 1'b0, 0);
    start(32'h900, 32'hA00, 16'd2, 1'b0, 0);
    run(300);
    checks++; if (obs !== expq) $display("FAIL after_reset_copy got %0d beats exp %0d", obs.size(), expq.size()); else passed++;
  endtask

  task automatic test_random_copy;
    for (int t = 0; t < 8; t++) begin
      logic [31:0] s, d;
      int len;
      seed = $urandom;
      s = (t == 0) ? 32'hFFFF_FFF3 : $urandom;
      d = $urandom;
      len = $urandom_range(13, 1);
      mode = 0; stall_pct = $urandom_range(40); gl_pct = $urandom_range(40); abort_on_wr = -1;
      build_exp(s, d, len, 1'b0, 0);
      start(s, d, 16'(len), 1'b0, 0);
      run(3000);
      checks++; if (obs.size() !== expq.size()) $display("FAIL rand%0d_beats got %0d exp %0d", t, obs.size(), expq.size()); else passed++;
      foreach (expq[i]) if (i < obs.size()) begin
        checks++; if (obs[i] !== expq[i]) $display("FAIL rand%0d_beat%0d got %h exp %h", t, i, obs[i], expq[i]); else passed++;
      end
      checks++; if (hold_err !== 0 || n_done !== 1 || aborted !== 1'b0) $display("FAIL rand%0d_status got %0d/%0d/%b exp 0/1/0", t, hold_err, n_done, aborted); else passed++;
    end
  endtask

`ifdef XT_HB_DMA_FILL_EN
  task automatic test_fill;
    mode = 0; stall_pct = 25; gl_pct = 25; abort_on_wr = -1;
    build_exp(32'h0, 32'h3FC, 5, 1'b1, 32'hDEAD_BEEF);
    start(32'h0, 32'h3FC, 16'd5, 1'b1, 32'hDEAD_BEEF);
    run(500);
    checks++; if (n_rd !== 0) $display("FAIL fill_reads got %0d exp 0", n_rd); else passed++;
    checks++; if (obs !== expq) $display("FAIL fill_writes got %0d beats exp %0d", obs.size(), expq.size()); else passed++;
    checks++; if (hold_err !== 0 || n_done !== 1) $display("FAIL fill_status got %0d/%0d exp 0/1", hold_err, n_done); else passed++;
    cfg_fill = 1'b0;
  endtask
`endif

  initial begin
    rst_sync = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0;
`ifdef XT_HB_DMA_FILL_EN
    cfg_fill = 1'b0; cfg_pattern = '0;
`endif
    read_grant = 1'b1; write_grant = 1'b1; stall_req = 1'b0;
    mode = 0; stall_pct = 0; gl_pct = 0; abort_on_wr = -1;
    @(posedge clk); #1;
    test_reset();
    test_idle_abort();
    test_len1_latency();
    test_zero_len();
    test_copy6(0);
    test_copy6(1);
    test_abort();
    test_reset_mid_read();
    test_random_copy();
`ifdef XT_HB_DMA_FILL_EN
    test_fill();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/xt_hb_dma.md
Name: xt_hb_dma

Overview:
- Single-channel word-copy DMA engine that acts as one master port on the high-speed bus arbiter/mux.
- Drives one `hb_master_in_t` slot and consumes that slot's `read_grant`, `write_grant` and `stall_req`.
- Reads up to `BUF_DEPTH` words from the source into a local buffer, then writes them to the destination. Repeats until the length is exhausted.
- Configured and monitored by a simple start/status port, normally wrapped by a low-speed register block.

Parameters:
- `BUF_DEPTH`, 4: burst buffer depth in 32-bit words; power of 2, range 1..16.
- `LEN_WIDTH`, 16: width of the word-count field.

Ports:
- `clk`  input  1  system clock
- `rst_sync`  input  1  synchronous active-high reset
- `cfg_start`  input  1  one-cycle start pulse; sampled only in IDLE
- `cfg_abort`  input  1  abort request; honoured in any state
- `cfg_src`  input  `HB_ADDR_WIDTH`  source byte address; word aligned, bits [1:0] ignored
- `cfg_dst`  input  `HB_ADDR_WIDTH`  destination byte address; word aligned, bits [1:0] ignored
- `cfg_len`  input  `LEN_WIDTH`  number of 32-bit words to copy
- `master_out`  output  `hb_master_in_t`  read/write/raddr/waddr/wdata/write_width request to the bus
- `read_grant`  input  1  this master's read grant bit
- `write_grant`  input  1  this master's write grant bit
- `stall_req`  input  1  this master's stall bit: arbitration lost or device not finished
- `busy`  output  1  high while not IDLE
- `done`  output  1  one-cycle pulse on completion or abort
- `aborted`  output  1  sticky; set on abort, cleared on the next accepted start
- `words_left`  output  `LEN_WIDTH`  remaining word count

Behaviour:
- Reset (`rst_sync`=1 at a clock edge) forces IDLE from any state, including mid-transfer:
  - `master_out` all zero; `busy`=0, `done`=0, `aborted`=0, `words_left`=0.
  - Buffer pointers cleared.
- `master_out.write_width` is always the full-word encoding from `XT_HBUS_Pkg` whenever `write`=1.
- DMA never asserts read and write in the same cycle.
- Beat completion rule: a read beat completes in a cycle with `master_out.read`=1, `read_grant`=1 and `stall_req`=0. Write beats use the same rule with `write` and `write_grant`.
- Request hold: address, data and request bit stay stable until the beat completes. No retraction except by abort or reset.
- Read data is captured from `hb_rdata` into the buffer on the completing cycle (`hb_rdata` is an input port at `HB_DATA` width 32).
  - Port addition: `hb_rdata`  input  32  bus read data.
- State machine:
  - IDLE: on `cfg_start` with `cfg_len`!=0, latch src/dst/len, clear `aborted`, go to READ. With `cfg_len`=0, go to DONE (no bus traffic).
  - READ: issue reads at `src`. Each completed beat: `src`+=4, buffer write pointer +1, `words_left`-1.
    - Go to WRITE when the buffer holds `BUF_DEPTH` words or `words_left` reaches 0.
  - WRITE: issue writes at `dst` with buffer data in FIFO order. Each completed beat: `dst`+=4, read pointer +1.
    - When the buffer is empty, go to READ if `words_left`!=0, else DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Request timing: the first request is asserted the cycle after entering READ or WRITE (registered outputs). Back-to-back beats with no idle cycle when grant is held and `stall_req`=0.
- Address arithmetic: modulo 2^`HB_ADDR_WIDTH`; wrap past top of address space silently.
- `cfg_start` while `busy` is ignored.
- Abort:
  - In READ/WRITE, `cfg_abort` completes an in-flight beat only if it completes in that same cycle. Otherwise the request drops next cycle.
  - Then DONE with `aborted`=1; buffer discarded.
  - Abort in IDLE has no effect.
  - Simultaneous start and abort in IDLE: start is ignored.
- Minimum latency for `cfg_len`=1 with no contention: start -> read beat 1 cycle later -> write beat 1 cycle after that -> `done` pulse on the following cycle.

Optional Feature:
- Macro `XT_HB_DMA_FILL_EN`. When defined, adds input `cfg_fill` (1) and input `cfg_pattern` (32).
  - With `cfg_fill`=1 at start, READ is skipped entirely: `words_left` words of `cfg_pattern` are written to `dst` directly.
  - `words_left` decrements per write beat; the buffer is unused.
- When undefined, the ports and the fill path do not exist; behaviour is copy-only.

Test Plan:
- Copy `len`=6, `BUF_DEPTH`=4, src=0x100, dst=0x200, grant always 1, no stalls:
  - reads 0x100..0x10C, writes 0x200..0x20C, then reads 0x110..0x114, writes 0x210..0x214.
  - data matches; one `done` pulse, `aborted`=0.
- Same copy with `stall_req` held 3 cycles on each read beat and `write_grant` low 2 cycles on the first write:
  - address and data held stable throughout; identical final memory; no dropped or duplicated beat.
- `cfg_len`=0 start -> no `read`/`write` ever asserted; `done` pulse 1 cycle after start; `busy` high exactly 1 cycle.
- Abort during the second write of an 8-word copy while stalled -> write drops next cycle, `done` pulses, `aborted`=1, destination holds exactly 1 written word.
- `rst_sync` asserted mid-READ with pending stall -> next cycle all outputs zero and IDLE. A subsequent start of `len`=2 completes normally.
- With `XT_HB_DMA_FILL_EN`: fill `len`=5, pattern 0xDEADBEEF, dst=0x3FC -> 5 writes at 0x3FC..0x40C, zero reads.
